// File: rtl/snake_pkg.sv
// Shared definitions for the snake command scheduler: command codes, register map,
// status bit positions and issue FSM states.
package snake_pkg;

  typedef enum logic [2:0] {
    CMD_NOP     = 3'd0,
    CMD_UP      = 3'd1,
    CMD_DOWN    = 3'd2,
    CMD_LEFT    = 3'd3,
    CMD_RIGHT   = 3'd4,
    CMD_PAUSE   = 3'd5,
    CMD_RESTART = 3'd6,
    CMD_RSVD    = 3'd7
  } cmd_t;

  localparam logic ADDR_CMD  = 1'b0;  // write: enqueue, read: status
  localparam logic ADDR_CTRL = 1'b1;  // write: flag clear, read: tick count

  localparam int ST_OVF_BIT   = 3;
  localparam int ST_MISS_BIT  = 4;
  localparam int ST_VALID_BIT = 5;

  typedef enum logic {
    S_IDLE,
    S_ISSUE
  } state_t;

  // Lowest key index wins when several keys edge together.
  function automatic logic [2:0] key_to_cmd(input logic [3:0] fall);
    logic [2:0] c;
    c = CMD_NOP;
    if (fall[0])      c = CMD_RIGHT;
    else if (fall[1]) c = CMD_DOWN;
    else if (fall[2]) c = CMD_UP;
    else if (fall[3]) c = CMD_LEFT;
    return c;
  endfunction

endpackage

// File: rtl/snake_cmd_fifo.sv
// Small synchronous command FIFO with occupancy count and a single-cycle flush.
module snake_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 3
) (
  input  logic                       clk,
  input  logic                       rst_ni,
  input  logic                       push_i,
  input  logic [W-1:0]               data_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  output logic [W-1:0]               data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign count_o = count_q;
  assign data_o  = mem[rd_q];

  // A push into a full FIFO is accepted only when a pop frees the slot this cycle.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q;
    if (flush_i) begin
      wr_d    = '0;
      rd_d    = '0;
      count_d = '0;
    end else begin
      if (do_push) wr_d = wr_q + 1'b1;
      if (do_pop)  rd_d = rd_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_q] <= data_i;
  end

endmodule

// File: rtl/snake_cmd_scheduler.sv
// Merges pushbutton and HPS direction commands into a FIFO and issues one command
// (FIFO head or NOP) per game tick to the snake datapath over valid/ready.
module snake_cmd_scheduler
  import snake_pkg::*;
#(
  parameter int TICK_CYCLES = 5_000_000,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [3:0]  key_n,
  input  logic        avs_address,
  input  logic        avs_write,
  input  logic [31:0] avs_writedata,
  input  logic        avs_read,
  output logic [31:0] avs_readdata,
  output logic        cmd_valid,
  output logic [2:0]  cmd_data,
  input  logic        cmd_ready,
  output logic        tick
);

  localparam int TW = $clog2(TICK_CYCLES);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [3:0]    key_s1_q, key_s2_q, key_s3_q, key_fall;
  logic          key_evt_q, key_evt_d;
  logic [2:0]    key_cmd_q, key_cmd_d;
  logic          pend_vld_q, pend_vld_d;
  logic [2:0]    pend_cmd_q, pend_cmd_d;
  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic          tick_q, tick_d;
  logic [31:0]   ticks_q, ticks_d;
  logic          ovf_q, ovf_d, miss_q, miss_d;
  state_t        state_q, state_d;
  logic [2:0]    cmd_data_q, cmd_data_d;
  logic [31:0]   rdata_q, rdata_d;

  logic          hps_push, key_vld, push, pop, flush, miss_set;
  logic [2:0]    key_sel, push_data, fifo_head;
  logic          fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count;
  logic [31:0]   status;
  logic          unused_wdata;

  assign unused_wdata = ^avs_writedata[31:3];

  // Falling edge on the synchronized key is a press.
  assign key_fall  = key_s3_q & ~key_s2_q;
  assign key_evt_d = |key_fall;
  assign key_cmd_d = key_to_cmd(key_fall);

  assign hps_push = avs_write && (avs_address == ADDR_CMD) &&
                    (avs_writedata[2:0] != CMD_NOP) && (avs_writedata[2:0] != CMD_RSVD);
  assign key_vld  = key_evt_q || pend_vld_q;
  assign key_sel  = key_evt_q ? key_cmd_q : pend_cmd_q;
  assign push      = !flush && (hps_push || key_vld);
  assign push_data = hps_push ? avs_writedata[2:0] : key_sel;

  // A key losing to HPS is parked; the newest key event always replaces it.
  always_comb begin
    pend_vld_d = 1'b0;
    pend_cmd_d = pend_cmd_q;
    if (!flush && hps_push && key_vld) begin
      pend_vld_d = 1'b1;
      pend_cmd_d = key_sel;
    end
  end

  assign tick_d     = (tick_cnt_q == TW'(TICK_CYCLES - 1));
  assign tick_cnt_d = tick_d ? '0 : tick_cnt_q + 1'b1;
  assign ticks_d    = ticks_q + 32'(tick_q);

  always_comb begin
    state_d    = state_q;
    cmd_data_d = cmd_data_q;
    pop        = 1'b0;
    miss_set   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (tick_q) begin
          pop        = !fifo_empty;
          cmd_data_d = fifo_empty ? CMD_NOP : fifo_head;
          state_d    = S_ISSUE;
        end
      end
      S_ISSUE: begin
        miss_set = tick_q;
        if (cmd_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign flush = pop && (fifo_head == CMD_RESTART);

  always_comb begin
    ovf_d  = ovf_q;
    miss_d = miss_q;
    if (avs_write && (avs_address == ADDR_CTRL)) begin
      if (avs_writedata[0]) ovf_d  = 1'b0;
      if (avs_writedata[1]) miss_d = 1'b0;
    end
    if (push && fifo_full && !pop) ovf_d = 1'b1;
    if (miss_set) miss_d = 1'b1;
  end

  always_comb begin
    status               = '0;
    status[2:0]          = 3'(fifo_count);
    status[ST_OVF_BIT]   = ovf_q;
    status[ST_MISS_BIT]  = miss_q;
    status[ST_VALID_BIT] = cmd_valid;
    rdata_d              = '0;
    if (avs_read) rdata_d = (avs_address == ADDR_CTRL) ? ticks_q : status;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      key_s1_q   <= '1;
      key_s2_q   <= '1;
      key_s3_q   <= '1;
      key_evt_q  <= 1'b0;
      key_cmd_q  <= '0;
      pend_vld_q <= 1'b0;
      pend_cmd_q <= '0;
      tick_cnt_q <= '0;
      tick_q     <= 1'b0;
      ticks_q    <= '0;
      ovf_q      <= 1'b0;
      miss_q     <= 1'b0;
      state_q    <= S_IDLE;
      cmd_data_q <= '0;
      rdata_q    <= '0;
    end else begin
      key_s1_q   <= key_n;
      key_s2_q   <= key_s1_q;
      key_s3_q   <= key_s2_q;
      key_evt_q  <= key_evt_d;
      key_cmd_q  <= key_cmd_d;
      pend_vld_q <= pend_vld_d;
      pend_cmd_q <= pend_cmd_d;
      tick_cnt_q <= tick_cnt_d;
      tick_q     <= tick_d;
      ticks_q    <= ticks_d;
      ovf_q      <= ovf_d;
      miss_q     <= miss_d;
      state_q    <= state_d;
      cmd_data_q <= cmd_data_d;
      rdata_q    <= rdata_d;
    end
  end

  snake_cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (3)
  ) u_fifo (
    .clk     (clk),
    .rst_ni  (reset_n),
    .push_i  (push),
    .data_i  (push_data),
    .pop_i   (pop),
    .flush_i (flush),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign cmd_valid    = (state_q == S_ISSUE);
  assign cmd_data     = cmd_data_q;
  assign tick         = tick_q;
  assign avs_readdata = rdata_q;

endmodule

// File: tb/tb_snake_cmd_scheduler.sv
// Directed bench for snake_cmd_scheduler with an 8-cycle game tick.
module tb_snake_cmd_scheduler;

  localparam int TICK = 8;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [3:0]  key_n = 4'hF;
  logic        avs_address = 1'b0;
  logic        avs_write = 1'b0;
  logic [31:0] avs_writedata = '0;
  logic        avs_read = 1'b0;
  logic [31:0] avs_readdata;
  logic        cmd_valid;
  logic [2:0]  cmd_data;
  logic        cmd_ready = 1'b1;
  logic        tick;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] rd;

  always #5 clk = ~clk;

  snake_cmd_scheduler #(
    .TICK_CYCLES (TICK),
    .FIFO_DEPTH  (4)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .key_n         (key_n),
    .avs_address   (avs_address),
    .avs_write     (avs_write),
    .avs_writedata (avs_writedata),
    .avs_read      (avs_read),
    .avs_readdata  (avs_readdata),
    .cmd_valid     (cmd_valid),
    .cmd_data      (cmd_data),
    .cmd_ready     (cmd_ready),
    .tick          (tick)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic hps_wr(input logic a, input logic [31:0] d);
    avs_address   = a;
    avs_writedata = d;
    avs_write     = 1'b1;
    @(negedge clk);
    avs_write     = 1'b0;
  endtask

  task automatic hps_rd(input logic a, output logic [31:0] d);
    avs_address = a;
    avs_read    = 1'b1;
    @(negedge clk);
    avs_read    = 1'b0;
    d           = avs_readdata;
  endtask

  // Returns on the negedge after the FSM has acted on the tick.
  task automatic wait_tick();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 3 * TICK; i++) begin
      @(negedge clk);
      if (tick) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) chk("tick_timeout", 32'd0, 32'd1);
    @(negedge clk);
  endtask

  task automatic expect_issue(input string tag, input logic [2:0] code);
    wait_tick();
    chk({tag, "_valid"}, 32'(cmd_valid), 32'd1);
    chk({tag, "_data"}, 32'(cmd_data), 32'(code));
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(cmd_valid), 32'd0);
    chk("rst_data", 32'(cmd_data), 32'd0);
    chk("rst_tick", 32'(tick), 32'd0);
    chk("rst_rdata", avs_readdata, 32'd0);

    // First tick 8 edges after release, NOP issued, ready=1 retires it.
    reset_n = 1'b1;
    repeat (7) @(negedge clk);
    chk("tick_pre", 32'(tick), 32'd0);
    @(negedge clk);
    chk("tick_first", 32'(tick), 32'd1);
    @(negedge clk);
    chk("nop_valid", 32'(cmd_valid), 32'd1);
    chk("nop_data", 32'(cmd_data), 32'd0);
    @(negedge clk);
    chk("nop_done", 32'(cmd_valid), 32'd0);
    hps_rd(1'b1, rd);
    chk("tick_count", rd, 32'd1);

    // HPS enqueue order.
    wait_tick();
    hps_wr(1'b0, 32'd1);
    hps_wr(1'b0, 32'd3);
    hps_wr(1'b0, 32'd4);
    hps_rd(1'b0, rd);
    chk("count3", rd, 32'd3);
    expect_issue("ord_up", 3'd1);
    expect_issue("ord_left", 3'd3);
    expect_issue("ord_right", 3'd4);

    // Key 3 press collides with an HPS DOWN write.
    key_n = 4'b0111;
    repeat (3) @(negedge clk);
    hps_wr(1'b0, 32'd2);
    @(negedge clk);
    key_n = 4'hF;
    hps_rd(1'b0, rd);
    chk("arb_count", rd, 32'd2);
    expect_issue("arb_down", 3'd2);
    expect_issue("arb_left", 3'd3);

    // Overflow and clear.
    hps_wr(1'b0, 32'd1);
    hps_wr(1'b0, 32'd2);
    hps_wr(1'b0, 32'd3);
    hps_wr(1'b0, 32'd4);
    hps_wr(1'b0, 32'd1);
    hps_rd(1'b0, rd);
    chk("ovf_status", rd, 32'd12);
    expect_issue("ovf_i0", 3'd1);
    hps_wr(1'b1, 32'd1);
    hps_rd(1'b0, rd);
    chk("ovf_cleared", rd, 32'd3);
    expect_issue("ovf_i1", 3'd2);
    expect_issue("ovf_i2", 3'd3);
    expect_issue("ovf_i3", 3'd4);

    // Missed tick while datapath stalls.
    hps_wr(1'b0, 32'd1);
    hps_wr(1'b0, 32'd2);
    cmd_ready = 1'b0;
    expect_issue("miss_i0", 3'd1);
    wait_tick();
    chk("miss_hold", 32'(cmd_data), 32'd1);
    hps_rd(1'b0, rd);
    chk("miss_status", rd, 32'd49);
    cmd_ready = 1'b1;
    @(negedge clk);
    chk("miss_retire", 32'(cmd_valid), 32'd0);
    hps_wr(1'b1, 32'd2);
    hps_rd(1'b0, rd);
    chk("miss_cleared", rd, 32'd1);
    expect_issue("miss_i1", 3'd2);

    // RESTART flushes the queued DOWN.
    hps_wr(1'b0, 32'd1);
    hps_wr(1'b0, 32'd6);
    hps_wr(1'b0, 32'd2);
    expect_issue("rs_up", 3'd1);
    expect_issue("rs_restart", 3'd6);
    @(negedge clk);
    hps_rd(1'b0, rd);
    chk("rs_count", rd, 32'd0);
    expect_issue("rs_nop", 3'd0);

    // Asynchronous reset while a command is outstanding.
    hps_wr(1'b0, 32'd5);
    cmd_ready = 1'b0;
    expect_issue("ar_pause", 3'd5);
    #2 reset_n = 1'b0;
    #1;
    chk("ar_valid", 32'(cmd_valid), 32'd0);
    chk("ar_data", 32'(cmd_data), 32'd0);
    @(negedge clk);
    reset_n   = 1'b1;
    cmd_ready = 1'b1;
    hps_rd(1'b0, rd);
    chk("ar_status", rd, 32'd0);
    hps_rd(1'b1, rd);
    chk("ar_ticks", rd, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
